// File: rtl/round_sequencer.sv
// Sequences the five round steps (par, rot, per, rev, RC) over a run of up to ROUNDS rounds.
// Define ROUND_SEQ_WATCHDOG_EN to build the per-step WAIT watchdog and the sticky err flag.
module round_sequencer #(
    parameter int unsigned ROUNDS = 24,
    parameter int unsigned RW     = 5,
    parameter int unsigned TO_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] n_rounds,
    input  logic [4:0]    skip_mask,
    input  logic          abort,
    input  logic [4:0]    step_ready,
    output logic [4:0]    step_start,
    output logic [RW-1:0] round_idx,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [RW-1:0] round_q, round_d;
    logic [RW-1:0] last_q, last_d;
    logic [4:0]    mask_q, mask_d;
    logic          err_q, err_d;
    logic [4:0]    step_start_q, step_start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [4:0]    higher;
    logic [RW-1:0] last_req;
    logic          wd_expired;

    function automatic logic [2:0] lowest_idx(logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 4; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            higher[i] = !mask_q[i] && (3'(i) > step_q);
        end
    end

    // Store N-1 rather than N so the terminal compare needs no extra bit.
    always_comb begin
        if (n_rounds == '0 || 32'(n_rounds) > ROUNDS) begin
            last_req = RW'(ROUNDS - 1);
        end else begin
            last_req = n_rounds - 1'b1;
        end
    end

`ifdef ROUND_SEQ_WATCHDOG_EN
    localparam logic [TO_W-1:0] WdLast = TO_W'((1 << TO_W) - 2);

    logic [TO_W-1:0] wd_q, wd_d;

    // wd_q counts completed WAIT cycles; expiry fires on the (2^TO_W-1)th one.
    assign wd_expired = (state_q == StWait) && (wd_q == WdLast);

    always_comb begin
        wd_d = wd_q;
        if (state_q == StIssue) begin
            wd_d = '0;
        end else if (state_q == StWait) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_to_w;
    assign unused_to_w = ^TO_W;
    assign wd_expired  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        round_d = round_q;
        last_d  = last_q;
        mask_d  = mask_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d  = skip_mask;
                    last_d  = last_req;
                    err_d   = 1'b0;
                    round_d = '0;
                    step_d  = lowest_idx(~skip_mask);
                    state_d = (&skip_mask) ? StDone : StIssue;
                end
            end
            StIssue: begin
                state_d = abort ? StIdle : StWait;
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (step_ready[step_q]) begin
                    if (|higher) begin
                        step_d  = lowest_idx(higher);
                        state_d = StIssue;
                    end else if (round_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        round_d = round_q + 1'b1;
                        step_d  = lowest_idx(~mask_q);
                        state_d = StIssue;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so derive them from the state being entered.
        step_start_d = (state_d == StIssue) ? (5'b00001 << step_d) : 5'b00000;
        busy_d       = (state_d == StIssue) || (state_d == StWait);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            step_q       <= 3'd0;
            round_q      <= '0;
            last_q       <= '0;
            mask_q       <= 5'b00000;
            err_q        <= 1'b0;
            step_start_q <= 5'b00000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            round_q      <= round_d;
            last_q       <= last_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
            step_start_q <= step_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign step_start = step_start_q;
    assign round_idx  = round_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: expected step pulses and done are queued per run
// and matched against the DUT outputs as they appear.
`timescale 1ns/1ps
module tb_round_sequencer;

    localparam int unsigned ROUNDS = 24;
    localparam int unsigned RW     = 5;
`ifdef ROUND_SEQ_WATCHDOG_EN
    localparam int unsigned TO_W   = 4;
`else
    localparam int unsigned TO_W   = 8;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [RW-1:0] n_rounds = '0;
    logic [4:0]    skip_mask = 5'b00000;
    logic          abort = 1'b0;
    logic [4:0]    step_ready = 5'b00000;
    logic [4:0]    step_start;
    logic [RW-1:0] round_idx;
    logic          busy;
    logic          done;
    logic          err;

    round_sequencer #(
        .ROUNDS (ROUNDS),
        .RW     (RW),
        .TO_W   (TO_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_rounds   (n_rounds),
        .skip_mask  (skip_mask),
        .abort      (abort),
        .step_ready (step_ready),
        .step_start (step_start),
        .round_idx  (round_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int            cyc;
        logic [4:0]    ss;
        logic [RW-1:0] ri;
        logic          dn;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_ev;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         rdy_mode = 0;
    int         rdy_cnt = 0;
    logic [4:0] rdy_pend = 5'b00000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected pulses for a run whose steps each take 1 ISSUE + k WAIT cycles.
    task automatic push_run(int n, logic [4:0] mask, int k);
        int  c;
        ev_t e;
        c = 1;
        for (int r = 0; r < n; r++) begin
            for (int s = 0; s < 5; s++) begin
                if (!mask[s]) begin
                    e.cyc = c;
                    e.ss  = 5'(1 << s);
                    e.ri  = RW'(r);
                    e.dn  = 1'b0;
                    exp_q.push_back(e);
                    c += 1 + k;
                end
            end
        end
        e.cyc = c;
        e.ss  = 5'b00000;
        e.ri  = (mask == 5'b11111) ? RW'(0) : RW'(n - 1);
        e.dn  = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic trim_exp(int keep);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
    endtask

    task automatic do_start(logic [RW-1:0] n, logic [4:0] m);
        @(negedge clk);
        start     = 1'b1;
        n_rounds  = n;
        skip_mask = m;
        @(posedge clk);
        #1;
        t0 = cyc - 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(int k);
        while ((cyc - t0) < k) @(negedge clk);
    endtask

    task automatic drain(int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
    endtask

    always @(negedge clk) begin
        if (step_start != 5'b00000 || done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ev", 32'({done, step_start}), 32'(0));
            end else begin
                mon_ev = exp_q.pop_front();
                check("ev_cycle", 32'(cyc - t0), 32'(mon_ev.cyc));
                check("ev_step_start", 32'(step_start), 32'(mon_ev.ss));
                check("ev_round_idx", 32'(round_idx), 32'(mon_ev.ri));
                check("ev_done", 32'(done), 32'(mon_ev.dn));
            end
        end
    end

    // Sub-unit model: 0 = ready tied high, 1 = ready 3 cycles after pulse, else never ready.
    always @(negedge clk) begin
        case (rdy_mode)
            0: step_ready = 5'b11111;
            1: begin
                step_ready = 5'b00000;
                if (rdy_cnt > 0) begin
                    rdy_cnt--;
                    if (rdy_cnt == 0) step_ready = rdy_pend;
                end
                if (step_start != 5'b00000) begin
                    rdy_pend = step_start;
                    rdy_cnt  = 3;
                end
            end
            default: step_ready = 5'b00000;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_step_start", 32'(step_start), 32'(0));
        check("rst_round_idx", 32'(round_idx), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        rst = 1'b1;
        @(negedge clk);

        // Default run: n_rounds=0 selects ROUNDS, no skips.
        push_run(ROUNDS, 5'b00000, 1);
        do_start(RW'(0), 5'b00000);
        wait_until(1);
        check("def_busy_c1", 32'(busy), 32'(1));
        wait_until(240);
        check("def_busy_c240", 32'(busy), 32'(1));
        wait_until(241);
        check("def_busy_c241", 32'(busy), 32'(0));
        drain(10);
        check("def_round_final", 32'(round_idx), 32'(ROUNDS - 1));

        // Skip steps 1 and 2 for three rounds.
        push_run(3, 5'b00110, 1);
        do_start(RW'(3), 5'b00110);
        drain(40);
        check("skip_round_final", 32'(round_idx), 32'(2));
        check("skip_busy_after", 32'(busy), 32'(0));

        // Slow ready, then abort during the round-1 WAIT of step 0.
        rdy_mode = 1;
        push_run(2, 5'b00000, 3);
        trim_exp(6);
        do_start(RW'(2), 5'b00000);
        wait_until(22);
        check("abort_round_c22", 32'(round_idx), 32'(1));
        check("abort_busy_c22", 32'(busy), 32'(1));
        abort = 1'b1;
        wait_until(23);
        abort = 1'b0;
        check("abort_busy_c23", 32'(busy), 32'(0));
        check("abort_step_c23", 32'(step_start), 32'(0));
        repeat (10) @(negedge clk);
        check("abort_queue", 32'(exp_q.size()), 32'(0));
        check("abort_no_done", 32'(done), 32'(0));
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // Every step skipped: done in cycle 1, no step pulses.
        push_run(5, 5'b11111, 1);
        do_start(RW'(5), 5'b11111);
        drain(5);
        check("allskip_round", 32'(round_idx), 32'(0));

        // n_rounds above ROUNDS clamps; a start mid-run must be ignored.
        push_run(ROUNDS, 5'b00000, 1);
        do_start(RW'(31), 5'b00000);
        wait_until(50);
        start     = 1'b1;
        n_rounds  = RW'(1);
        skip_mask = 5'b11111;
        wait_until(51);
        start = 1'b0;
        check("busy_start_round", 32'(round_idx), 32'(5));
        check("busy_start_step", 32'(step_start), 32'(1));
        drain(250);
        check("clamp_round_final", 32'(round_idx), 32'(ROUNDS - 1));

        // Ready never arrives.
        rdy_mode = 2;
        push_run(1, 5'b00000, 1);
        trim_exp(1);
        do_start(RW'(1), 5'b00000);
`ifdef ROUND_SEQ_WATCHDOG_EN
        wait_until(16);
        check("wd_busy_c16", 32'(busy), 32'(1));
        check("wd_err_c16", 32'(err), 32'(0));
        wait_until(17);
        check("wd_err_c17", 32'(err), 32'(1));
        check("wd_busy_c17", 32'(busy), 32'(0));
        check("wd_done_c17", 32'(done), 32'(0));
        rdy_mode = 0;
        push_run(1, 5'b11111, 1);
        do_start(RW'(1), 5'b11111);
        check("wd_err_cleared", 32'(err), 32'(0));
        drain(5);
`else
        wait_until(40);
        check("hang_busy_c40", 32'(busy), 32'(1));
        check("hang_err_c40", 32'(err), 32'(0));
        check("hang_round_c40", 32'(round_idx), 32'(0));
        abort = 1'b1;
        wait_until(41);
        abort = 1'b0;
        check("hang_busy_c41", 32'(busy), 32'(0));
        check("hang_err_c41", 32'(err), 32'(0));
        rdy_mode = 0;
`endif
        check("hang_queue", 32'(exp_q.size()), 32'(0));
        repeat (2) @(negedge clk);

        // Reset during the WAIT of round 5, then a fresh run.
        push_run(ROUNDS, 5'b00000, 1);
        trim_exp(26);
        do_start(RW'(0), 5'b00000);
        wait_until(52);
        check("mid_round_c52", 32'(round_idx), 32'(5));
        check("mid_busy_c52", 32'(busy), 32'(1));
        check("mid_queue", 32'(exp_q.size()), 32'(0));
        rst = 1'b0;
        #1;
        check("mid_rst_step_start", 32'(step_start), 32'(0));
        check("mid_rst_round_idx", 32'(round_idx), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_err", 32'(err), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_run(2, 5'b00000, 1);
        do_start(RW'(2), 5'b00000);
        check("restart_round_c1", 32'(round_idx), 32'(0));
        drain(30);
        check("restart_round_final", 32'(round_idx), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
